run_controller: RTL and testbench

//   Sequences the single-cycle core through one program run: start/ack handshake with the

---
 rtl/run_controller.sv | 104 ++++++++++
 tb/tb_run_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Program-run sequencer for the single-cycle core: start/ack handshake, core-clear init phase,
// datapath gating (run_en) and a RUN-cycle watchdog.
module run_controller #(
   parameter int unsigned MAX_CYCLES  = 4096,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned INIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             done_instr,
   output logic             run_en,
   output logic             core_clear,
   output logic             ack,
   output logic             timed_out,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [InitW-1:0] InitLoad     = InitW'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LastRunCount = CNT_W'(MAX_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StArmed   = 3'd1,
      StInit    = 3'd2,
      StRun     = 3'd3,
      StDone    = 3'd4,
      StTimeout = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [InitW-1:0]  init_cnt_q, init_cnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         init_cnt_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      cnt_d      = cnt_q;
      case (state_q)
         StIdle: begin
            if (start) state_d = StArmed;
         end
         StArmed: begin
            // The run is launched by the falling edge of start, not its level.
            if (!start) begin
               state_d    = StInit;
               init_cnt_d = InitLoad;
               cnt_d      = '0;
            end
         end
         StInit: begin
            if (init_cnt_q == '0) state_d = StRun;
            else                  init_cnt_d = init_cnt_q - InitW'(1);
         end
         StRun: begin
            cnt_d = cnt_q + CNT_W'(1);
            // DONE wins over the watchdog when both land on the same cycle.
            if (done_instr)                  state_d = StDone;
            else if (cnt_q == LastRunCount)  state_d = StTimeout;
         end
         StDone, StTimeout: begin
            if (start) state_d = StArmed;
         end
         default: begin
            state_d    = StIdle;
            init_cnt_d = '0;
            cnt_d      = '0;
         end
      endcase
   end

   always_comb begin
      run_en      = 1'b0;
      core_clear  = 1'b0;
      ack         = 1'b0;
      timed_out   = 1'b0;
      cycle_count = cnt_q;
      case (state_q)
         StIdle, StArmed: ;
         StInit:    core_clear = 1'b1;
         StRun:     run_en     = 1'b1;
         StDone:    ack        = 1'b1;
         StTimeout: begin
            ack       = 1'b1;
            timed_out = 1'b1;
         end
         default:   cycle_count = '0;
      endcase
   end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller built with a 16-cycle watchdog so timeout paths stay short.
module tb_run_controller;

   localparam int unsigned MaxCycles = 16;
   localparam int unsigned CntW      = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            done_instr;
   logic            run_en;
   logic            core_clear;
   logic            ack;
   logic            timed_out;
   logic [CntW-1:0] cycle_count;

   int n_cmp = 0;
   int n_bad = 0;

   run_controller #(
      .MAX_CYCLES (MaxCycles),
      .CNT_W      (CntW),
      .INIT_CYCLES(2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .done_instr (done_instr),
      .run_en     (run_en),
      .core_clear (core_clear),
      .ack        (ack),
      .timed_out  (timed_out),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expects the DUT in ARMED; drops start and follows the run until ack.
   // noise=1 pokes start/done_instr where they must be ignored.
   task automatic run_program(input int done_at, input bit noise,
                              output int clear_cnt, output int run_cnt);
      bit finished;
      finished   = 1'b0;
      clear_cnt  = 0;
      run_cnt    = 0;
      start      = 1'b0;
      done_instr = 1'b0;
      for (int i = 0; i < 100 && !finished; i++) begin
         tick();
         if (ack) begin
            finished   = 1'b1;
            start      = 1'b0;
            done_instr = 1'b0;
         end else if (core_clear) begin
            clear_cnt++;
            start      = noise;
            done_instr = noise;
         end else if (run_en) begin
            run_cnt++;
            done_instr = (run_cnt == done_at);
            start      = noise && (run_cnt == 3 || run_cnt == 5);
         end else begin
            start      = 1'b0;
            done_instr = 1'b0;
         end
      end
      start      = 1'b0;
      done_instr = 1'b0;
      n_cmp++;
      if (!finished) begin
         n_bad++;
         $display("FAIL run_finish: ack=%0b after 100 cycles, want 1", ack);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; done_instr = 1'b0;
      tick(); tick();
      n_cmp++; if (run_en !== 1'b0) begin n_bad++; $display("FAIL reset_run_en: got %0b want 0", run_en); end
      n_cmp++; if (core_clear !== 1'b0) begin n_bad++; $display("FAIL reset_core_clear: got %0b want 0", core_clear); end
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %0b want 0", ack); end
      n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL reset_timed_out: got %0b want 0", timed_out); end
      n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
      reset = 1'b0;
      tick();
      n_cmp++; if ({run_en, core_clear, ack} !== 3'b000) begin n_bad++; $display("FAIL idle_hold: got %b want 000", {run_en, core_clear, ack}); end
   endtask

   // T1: start high 3 cycles, done on the 10th RUN cycle.
   task automatic test_done_run();
      int c, r;
      start = 1'b1;
      tick(); tick(); tick();
      n_cmp++; if ({core_clear, run_en, ack} !== 3'b000) begin n_bad++; $display("FAIL armed_outputs: got %b want 000", {core_clear, run_en, ack}); end
      run_program(10, 1'b0, c, r);
      n_cmp++; if (c !== 2) begin n_bad++; $display("FAIL t1_clear_cycles: got %0d want 2", c); end
      n_cmp++; if (r !== 10) begin n_bad++; $display("FAIL t1_run_cycles: got %0d want 10", r); end
      n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL t1_timed_out: got %0b want 0", timed_out); end
      n_cmp++; if (cycle_count !== 16'd10) begin n_bad++; $display("FAIL t1_count: got %0d want 10", cycle_count); end
      done_instr = 1'b1;
      tick(); tick();
      done_instr = 1'b0;
      n_cmp++; if (cycle_count !== 16'd10) begin n_bad++; $display("FAIL t1_count_frozen: got %0d want 10", cycle_count); end
      n_cmp++; if ({ack, run_en} !== 2'b10) begin n_bad++; $display("FAIL t1_ack_held: got %b want 10", {ack, run_en}); end
   endtask

   // T6: restart after DONE, start held high across ARMED, done on 3rd RUN cycle.
   task automatic test_restart();
      int c, r;
      start = 1'b1;
      tick();
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL t6_ack_drop: got %0b want 0", ack); end
      n_cmp++; if (cycle_count !== 16'd10) begin n_bad++; $display("FAIL t6_armed_count: got %0d want 10", cycle_count); end
      tick(); tick();
      n_cmp++; if ({core_clear, run_en} !== 2'b00) begin n_bad++; $display("FAIL t6_wait_fall: got %b want 00", {core_clear, run_en}); end
      run_program(3, 1'b0, c, r);
      n_cmp++; if (r !== 3) begin n_bad++; $display("FAIL t6_run_cycles: got %0d want 3", r); end
      n_cmp++; if (cycle_count !== 16'd3) begin n_bad++; $display("FAIL t6_count: got %0d want 3", cycle_count); end
      n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL t6_timed_out: got %0b want 0", timed_out); end
   endtask

   // T2: no done -> watchdog after exactly MaxCycles RUN cycles.
   task automatic test_timeout();
      int c, r;
      start = 1'b1;
      tick();
      run_program(0, 1'b0, c, r);
      n_cmp++; if (r !== 16) begin n_bad++; $display("FAIL t2_run_cycles: got %0d want 16", r); end
      n_cmp++; if (timed_out !== 1'b1) begin n_bad++; $display("FAIL t2_timed_out: got %0b want 1", timed_out); end
      n_cmp++; if (cycle_count !== 16'd16) begin n_bad++; $display("FAIL t2_count: got %0d want 16", cycle_count); end
      start = 1'b1;
      tick();
      n_cmp++; if ({ack, timed_out} !== 2'b00) begin n_bad++; $display("FAIL t2_rearm_clear: got %b want 00", {ack, timed_out}); end
      n_cmp++; if (cycle_count !== 16'd16) begin n_bad++; $display("FAIL t2_armed_count: got %0d want 16", cycle_count); end
   endtask

   // T3: done on the very cycle the watchdog would fire; DONE must win.
   task automatic test_done_at_limit();
      int c, r;
      run_program(16, 1'b0, c, r);
      n_cmp++; if (r !== 16) begin n_bad++; $display("FAIL t3_run_cycles: got %0d want 16", r); end
      n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL t3_timed_out: got %0b want 0", timed_out); end
      n_cmp++; if (cycle_count !== 16'd16) begin n_bad++; $display("FAIL t3_count: got %0d want 16", cycle_count); end
   endtask

   // T4: done_instr outside RUN and start during INIT/RUN change nothing.
   task automatic test_ignored();
      int c, r;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      done_instr = 1'b1;
      tick();
      n_cmp++; if ({core_clear, run_en, ack} !== 3'b000) begin n_bad++; $display("FAIL t4_idle_done: got %b want 000", {core_clear, run_en, ack}); end
      start = 1'b1;
      tick(); tick();
      n_cmp++; if ({core_clear, run_en, ack} !== 3'b000) begin n_bad++; $display("FAIL t4_armed_done: got %b want 000", {core_clear, run_en, ack}); end
      run_program(10, 1'b1, c, r);
      n_cmp++; if (c !== 2) begin n_bad++; $display("FAIL t4_clear_cycles: got %0d want 2", c); end
      n_cmp++; if (r !== 10) begin n_bad++; $display("FAIL t4_run_cycles: got %0d want 10", r); end
      n_cmp++; if (cycle_count !== 16'd10) begin n_bad++; $display("FAIL t4_count: got %0d want 10", cycle_count); end
   endtask

   // T5: reset on the 5th RUN cycle aborts to IDLE; a fresh run still works.
   task automatic test_mid_run_reset();
      int c, r, seen;
      start = 1'b1;
      tick();
      start = 1'b0;
      seen  = 0;
      for (int i = 0; i < 40 && seen < 5; i++) begin
         tick();
         if (run_en) seen++;
      end
      n_cmp++; if (seen !== 5) begin n_bad++; $display("FAIL t5_reach_run: got %0d RUN cycles want 5", seen); end
      reset = 1'b1;
      tick();
      n_cmp++; if ({run_en, core_clear, ack, timed_out} !== 4'b0000) begin n_bad++; $display("FAIL t5_abort_outputs: got %b want 0000", {run_en, core_clear, ack, timed_out}); end
      n_cmp++; if (cycle_count !== 16'd0) begin n_bad++; $display("FAIL t5_abort_count: got %0d want 0", cycle_count); end
      reset = 1'b0;
      tick(); tick();
      n_cmp++; if ({run_en, core_clear} !== 2'b00) begin n_bad++; $display("FAIL t5_stays_idle: got %b want 00", {run_en, core_clear}); end
      start = 1'b1;
      tick();
      run_program(4, 1'b0, c, r);
      n_cmp++; if (cycle_count !== 16'd4) begin n_bad++; $display("FAIL t5_rerun_count: got %0d want 4", cycle_count); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; done_instr = 1'b0;
      test_reset();
      test_done_run();
      test_restart();
      test_timeout();
      test_done_at_limit();
      test_ignored();
      test_mid_run_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
